mips_scoreboard: RTL and testbench

MIPS_SCOREBOARD -- requirements
Module: mips_scoreboard

---
 rtl/mips_scoreboard.sv | 134 +++++++++++++
 tb/tb_mips_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_scoreboard.sv
// Register scoreboard for an in-order MIPS-style issue stage: tracks pending
// writebacks through a fixed-latency pipeline and stalls issue on RAW/WAW hazards.
module mips_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned LAT  = 3,
  parameter int          FWD  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wen,
  input  logic            issue_halt,
  input  logic            flush,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [NREG-1:0] busy,
  output logic            halted,
  output logic [15:0]     stall_cnt
);

  // The issuing instruction itself occupies slot 0 in its issue cycle, so only
  // LAT-1 registered stages follow it; the writeback register plays the final slot.
  localparam int unsigned DEPTH = (LAT > 1) ? LAT - 1 : 1;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [DEPTH-1:0] stage_v;
  logic [AW-1:0]   stage_rd [DEPTH];
  logic [NREG-1:0] busy_all;
  logic [NREG-1:0] busy_raw;
  logic            raw_hit;
  logic            waw_hit;
  logic            hazard;
  logic            accept;
  logic            load_v;
  logic            tail_v;
  logic [AW-1:0]   tail_rd;
  logic            stages_empty;

  always_comb begin
    busy_all = '0;
    busy_raw = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (stage_v[i]) begin
        busy_all[stage_rd[i]] = 1'b1;
        // With bypass, the producer about to write back can forward its result.
        if (!(FWD != 0 && i == DEPTH - 1))
          busy_raw[stage_rd[i]] = 1'b1;
      end
    end
    busy_all[0] = 1'b0;
    busy_raw[0] = 1'b0;
  end

  always_comb begin
    raw_hit = ((issue_rs != '0) && busy_raw[issue_rs]) ||
              ((issue_rt != '0) && busy_raw[issue_rt]);
    waw_hit = issue_wen && !issue_halt && busy_all[issue_rd];
    hazard  = raw_hit || waw_hit;
  end

  assign issue_ready  = (state == RUN) && !flush && !hazard;
  assign accept       = issue_valid && issue_ready;
  assign load_v       = accept && issue_wen && !issue_halt && (issue_rd != '0);
  assign stages_empty = (stage_v == '0);

  always_comb begin
    if (LAT > 1) begin
      tail_v  = stage_v[DEPTH-1];
      tail_rd = stage_rd[DEPTH-1];
    end else begin
      tail_v  = load_v;
      tail_rd = issue_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        stage_rd[i] <= '0;
    end else begin
      wb_valid <= tail_v && !flush;
      if (tail_v && !flush)
        wb_rd <= tail_rd;
      if (flush) begin
        stage_v <= '0;
      end else begin
        stage_v[0] <= (LAT > 1) ? load_v : 1'b0;
        for (int unsigned i = 1; i < DEPTH; i++)
          stage_v[i] <= stage_v[i-1];
      end
      stage_rd[0] <= issue_rd;
      for (int unsigned i = 1; i < DEPTH; i++)
        stage_rd[i] <= stage_rd[i-1];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && issue_halt) state_next = DRAIN;
      DRAIN:   if (flush || stages_empty) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == RUN && issue_valid && !issue_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign busy   = busy_all;
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_mips_scoreboard.sv
// Self-checking bench for mips_scoreboard: scoreboard of expected writebacks
// plus directed hazard, drain, flush, saturation and reset checks.
module tb_mips_scoreboard;

  localparam int LAT = 3;

  typedef struct {
    logic [4:0] rd;
    int         due;
  } wb_t;

  logic        clk;
  logic        rst;
  logic        issue_valid, issue_ready, issue_wen, issue_halt, flush;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        wb_valid, halted;
  logic [4:0]  wb_rd;
  logic [31:0] busy;
  logic [15:0] stall_cnt;

  logic        f_issue_valid, f_issue_ready, f_issue_wen, f_issue_halt, f_flush;
  logic [4:0]  f_issue_rs, f_issue_rt, f_issue_rd;
  logic        f_wb_valid, f_halted;
  logic [4:0]  f_wb_rd;
  logic [31:0] f_busy;
  logic [15:0] f_stall_cnt;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  wb_t sb[$];

  mips_scoreboard #(.NREG(32), .LAT(LAT), .FWD(0)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .issue_halt(issue_halt), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  mips_scoreboard #(.NREG(32), .LAT(LAT), .FWD(1)) dut_f (
    .clk(clk), .rst(rst),
    .issue_valid(f_issue_valid), .issue_ready(f_issue_ready),
    .issue_rs(f_issue_rs), .issue_rt(f_issue_rt), .issue_rd(f_issue_rd),
    .issue_wen(f_issue_wen), .issue_halt(f_issue_halt), .flush(f_flush),
    .wb_valid(f_wb_valid), .wb_rd(f_wb_rd), .busy(f_busy),
    .halted(f_halted), .stall_cnt(f_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Retirements of the FWD=0 instance are matched against the queue in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", {31'b0, wb_valid}, 32'h0);
        end else begin
          wb_t e;
          e = sb.pop_front();
          check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          check("wb_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("wb_missing", {31'b0, wb_valid}, 32'h1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
    issue_wen = 0; issue_halt = 0; flush = 0;
    f_issue_valid = 0; f_issue_rs = 0; f_issue_rt = 0; f_issue_rd = 0;
    f_issue_wen = 0; f_issue_halt = 0; f_flush = 0;
  endtask

  task automatic purge(input int c);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > c) sb.delete(i);
  endtask

  task automatic drive(input bit sel, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit wen, input bit halt, input bit fl,
                       input bit exp_rdy, input string tag);
    clear_inputs();
    if (!sel) begin
      issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd;
      issue_wen = wen; issue_halt = halt; flush = fl;
    end else begin
      f_issue_valid = v; f_issue_rs = rs; f_issue_rt = rt; f_issue_rd = rd;
      f_issue_wen = wen; f_issue_halt = halt; f_flush = fl;
    end
    @(negedge clk);
    check(tag, {31'b0, sel ? f_issue_ready : issue_ready}, {31'b0, exp_rdy});
    if (!sel && v && exp_rdy && wen && !halt && rd != 0)
      sb.push_back('{rd, cyc + LAT});
    if (!sel && fl) purge(cyc);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1;
    #2;
    check("rst_busy", busy, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_stall", {16'b0, stall_cnt}, 32'h0);
    check("rst_wb", {31'b0, wb_valid}, 32'h0);
    check("rst_ready", {31'b0, issue_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 0;

    // RAW without bypass: ADDI R1 then ADD R4,R1,R2
    drive(0, 1, 0, 0, 1, 1, 0, 0, 1, "raw_addi");
    drive(0, 1, 1, 2, 4, 1, 0, 0, 0, "raw_stall1");
    drive(0, 1, 1, 2, 4, 1, 0, 0, 0, "raw_stall2");
    drive(0, 1, 1, 2, 4, 1, 0, 0, 1, "raw_accept");
    check("raw_stall_cnt", {16'b0, stall_cnt}, 32'd2);
    check("raw_busy", busy, 32'h10);
    idle(3);

    // RAW with bypass on the FWD=1 instance
    drive(1, 1, 0, 0, 1, 1, 0, 0, 1, "fwd_addi");
    drive(1, 1, 1, 2, 4, 1, 0, 0, 0, "fwd_stall1");
    drive(1, 1, 1, 2, 4, 1, 0, 0, 1, "fwd_accept");
    check("fwd_stall_cnt", {16'b0, f_stall_cnt}, 32'd1);
    check("fwd_wb_valid", {31'b0, f_wb_valid}, 32'h1);
    check("fwd_wb_rd", {27'b0, f_wb_rd}, 32'd1);
    drive(1, 1, 0, 0, 5, 1, 0, 0, 1, "fwd_waw_a");
    drive(1, 1, 0, 0, 5, 1, 0, 0, 0, "fwd_waw_s1");
    drive(1, 1, 0, 0, 5, 1, 0, 0, 0, "fwd_waw_s2");
    drive(1, 1, 0, 0, 5, 1, 0, 0, 1, "fwd_waw_b");
    check("fwd_waw_stall_cnt", {16'b0, f_stall_cnt}, 32'd3);
    idle(4);

    // Back-to-back independent writes
    drive(0, 1, 0, 0, 1, 1, 0, 0, 1, "b2b_r1");
    drive(0, 1, 0, 0, 2, 1, 0, 0, 1, "b2b_r2");
    drive(0, 1, 0, 0, 3, 1, 0, 0, 1, "b2b_r3");
    check("b2b_busy3", busy, 32'hC);
    idle(1);
    check("b2b_busy4", busy, 32'h8);
    idle(2);
    check("b2b_busy6", busy, 32'h0);

    // R0 destination is never tracked; WAW on R5
    drive(0, 1, 0, 0, 0, 1, 0, 0, 1, "r0_issue");
    check("r0_busy", busy, 32'h0);
    drive(0, 1, 0, 0, 5, 1, 0, 0, 1, "waw_a");
    drive(0, 1, 0, 0, 5, 1, 0, 0, 0, "waw_s1");
    drive(0, 1, 0, 0, 5, 1, 0, 0, 0, "waw_s2");
    drive(0, 1, 0, 0, 5, 1, 0, 0, 1, "waw_b");
    check("waw_stall_cnt", {16'b0, stall_cnt}, 32'd4);
    idle(4);

    // HLT after two writes drains then halts
    drive(0, 1, 0, 0, 6, 1, 0, 0, 1, "hlt_w6");
    drive(0, 1, 0, 0, 7, 1, 0, 0, 1, "hlt_w7");
    drive(0, 1, 0, 0, 9, 1, 1, 0, 1, "hlt_accept");
    check("hlt_busy", busy, 32'h80);
    drive(0, 1, 0, 0, 10, 1, 0, 0, 0, "drain_ready");
    check("drain_halted", {31'b0, halted}, 32'h0);
    idle(1);
    check("halted_set", {31'b0, halted}, 32'h1);
    check("drain_stall_cnt", {16'b0, stall_cnt}, 32'd4);
    drive(0, 1, 0, 0, 11, 1, 0, 0, 0, "halted_ready");
    check("halted_held", {31'b0, halted}, 32'h1);
    do_reset();

    // Flush during DRAIN discards the pending write
    drive(0, 1, 0, 0, 1, 1, 0, 0, 1, "fl_w1");
    drive(0, 1, 0, 0, 0, 0, 1, 0, 1, "fl_hlt");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "fl_ready");
    check("fl_halted", {31'b0, halted}, 32'h1);
    check("fl_wb", {31'b0, wb_valid}, 32'h0);
    check("fl_busy", busy, 32'h0);
    idle(3);
    do_reset();

    // Flush in RUN blocks issue; held flush saturates the stall counter
    drive(0, 1, 0, 0, 3, 1, 0, 1, 0, "run_flush_ready");
    check("run_flush_stall", {16'b0, stall_cnt}, 32'd1);
    issue_valid = 1; flush = 1;
    repeat (65533) @(posedge clk);
    #1;
    check("sat_fffe", {16'b0, stall_cnt}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", {16'b0, stall_cnt}, 32'hFFFF);
    idle(1);

    // Asynchronous reset mid-pipeline
    drive(0, 1, 0, 0, 1, 1, 0, 0, 1, "ar_w1");
    drive(0, 1, 0, 0, 2, 1, 0, 0, 1, "ar_w2");
    check("ar_busy_before", busy, 32'h6);
    rst = 1;
    sb.delete();
    #1;
    check("ar_busy", busy, 32'h0);
    check("ar_stall", {16'b0, stall_cnt}, 32'h0);
    check("ar_wb", {31'b0, wb_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    idle(5);
    check("ar_busy_after", busy, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
